// File: rtl/audio_gain_stage.sv
// -----------------------------------------------------------------------------
// audio_gain_stage
//
// Stereo gain stage between the DMA engine and the DMA-to-CODEC FIFO. Each
// 64-bit AXI-stream beat carries two 32-bit lanes (left in [63:32], right in
// [31:0]). A signed sample sits in the low SAMPLE_WIDTH bits of each lane, and
// the upper lane bits are ignored. Both lanes are multiplied by the same
// unsigned Q1.15 gain (16'h8000 = unity), arithmetically shifted right by 15
// (truncating toward negative infinity), saturated to SAMPLE_WIDTH bits and
// sign-extended back to 32 bits.
//
// Pipeline: stage 1 registers the beat, tlast and the gain in effect when the
// beat is accepted. Stage 2 multiplies, shifts and saturates into the output
// register. A full, stalled pipeline holds its output stable.
//
// Optional feature (define AUDIO_GAIN_SOFT_MUTE_EN):
//   When defined, the effective gain ramps by RAMP_STEP per accepted beat
//   toward 0 (mute=1) or toward the target gain (mute=0), clamping at the
//   destination. When undefined, the effective gain switches to 0 or to the
//   target immediately, and ramp_active is tied low.
//
// Parameters:
//   SAMPLE_WIDTH  signed sample width inside each 32-bit lane (2..32)
//   RAMP_STEP     gain change per accepted beat while ramping
//
// Ports:
//   clock          AXI-stream clock
//   reset          synchronous, active-high
//   s_axis_*       upstream beat (tvalid/tready/tdata[63:0]/tlast)
//   m_axis_*       downstream beat toward the CODEC FIFO
//   gain_in        unsigned Q1.15 gain value
//   gain_load      one-cycle pulse latching gain_in into the target gain
//   mute           level; 1 drives the output toward silence
//   sat_clear      clears sat_count (wins over a simultaneous increment)
//   sat_count      saturated-lane counter, sticks at 16'hFFFF
//   ramp_active    effective gain differs from its destination
// -----------------------------------------------------------------------------
module audio_gain_stage #(
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter logic [15:0] RAMP_STEP    = 16'h0100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic [15:0] gain_in,
    input  logic        gain_load,
    input  logic        mute,
    input  logic        sat_clear,
    output logic [15:0] sat_count,
    output logic        ramp_active
);

    // Product of a SAMPLE_WIDTH signed sample and a 17-bit non-negative gain.
    localparam int unsigned PROD_W = SAMPLE_WIDTH + 17;
    localparam logic [15:0] UNITY_GAIN = 16'h8000;

    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W - SAMPLE_WIDTH + 1){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W - SAMPLE_WIDTH + 1){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}};

    // Signed sample times zero-extended gain, then >>> 15. The shift floors,
    // so negative fractions move away from zero (no rounding).
    function automatic logic signed [PROD_W-1:0] scale_lane(
        input logic signed [SAMPLE_WIDTH-1:0] sample,
        input logic        [15:0]             gain
    );
        logic signed [PROD_W-1:0] sample_x;
        logic signed [PROD_W-1:0] gain_x;
        sample_x   = PROD_W'(sample);
        gain_x     = {{(PROD_W - 16){1'b0}}, gain};
        scale_lane = (sample_x * gain_x) >>> 15;
    endfunction

    // Clamp to the SAMPLE_WIDTH signed range and sign-extend to 32 bits.
    // Bit 32 of the result flags that clamping happened.
    function automatic logic [32:0] sat_lane(
        input logic signed [PROD_W-1:0] value
    );
        logic signed [SAMPLE_WIDTH-1:0] clipped;
        logic signed [31:0]             extended;
        logic                           hit;
        if (value > SAT_MAX) begin
            clipped = SAT_MAX[SAMPLE_WIDTH-1:0];
            hit     = 1'b1;
        end else if (value < SAT_MIN) begin
            clipped = SAT_MIN[SAMPLE_WIDTH-1:0];
            hit     = 1'b1;
        end else begin
            clipped = value[SAMPLE_WIDTH-1:0];
            hit     = 1'b0;
        end
        extended = 32'(clipped);
        sat_lane = {hit, extended};
    endfunction

    // Handshake and pipeline control
    logic                           vld_p1;
    logic                           vld_p2;
    logic                           accept;
    logic                           adv_p2;
    logic                           out_fire;

    logic signed [SAMPLE_WIDTH-1:0] sample_l_p1;
    logic signed [SAMPLE_WIDTH-1:0] sample_r_p1;
    logic                           last_p1;
    logic        [15:0]             gain_p1;

    logic        [63:0]             data_p2;
    logic                           last_p2;
    logic                           sat_l_p2;
    logic                           sat_r_p2;

    logic        [32:0]             res_l;
    logic        [32:0]             res_r;

    logic        [15:0]             target_gain;
    logic        [15:0]             eff_gain;
    logic        [15:0]             dest_gain;
    logic        [16:0]             sat_sum;

    // Stage 2 can take a new beat when empty or when its beat is leaving.
    // Ready depends only on registered flags, m_axis_tready and reset.
    assign adv_p2        = !vld_p2 || m_axis_tready;
    assign out_fire      = vld_p2 && m_axis_tready;
    assign s_axis_tready = !reset && (!vld_p1 || !vld_p2 || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Gain control
    always_ff @(posedge clock) begin
        if (reset) begin
            target_gain <= UNITY_GAIN;
        end else if (gain_load) begin
            target_gain <= gain_in;
        end
    end

    // While muted a gain_load only moves the target; the destination stays 0.
    assign dest_gain = mute ? 16'h0000 : target_gain;

`ifdef AUDIO_GAIN_SOFT_MUTE_EN
    logic [15:0] eff_next;

    // One RAMP_STEP toward the destination, landing exactly on it when the
    // remaining distance is a step or less. A direction change simply starts
    // from wherever eff_gain currently is.
    always_comb begin
        eff_next = eff_gain;
        if (eff_gain < dest_gain) begin
            if ((dest_gain - eff_gain) <= RAMP_STEP) begin
                eff_next = dest_gain;
            end else begin
                eff_next = eff_gain + RAMP_STEP;
            end
        end else if (eff_gain > dest_gain) begin
            if ((eff_gain - dest_gain) <= RAMP_STEP) begin
                eff_next = dest_gain;
            end else begin
                eff_next = eff_gain - RAMP_STEP;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            eff_gain <= UNITY_GAIN;
        end else if (accept) begin
            eff_gain <= eff_next;
        end
    end

    assign ramp_active = (eff_gain != dest_gain);
`else
    logic [15:0] unused_ramp_step;

    assign eff_gain         = dest_gain;
    assign ramp_active      = 1'b0;
    assign unused_ramp_step = RAMP_STEP;
`endif

    generate
        if (SAMPLE_WIDTH < 32) begin : g_unused_hi
            logic unused_hi_bits;
            assign unused_hi_bits = ^{s_axis_tdata[63:32+SAMPLE_WIDTH],
                                      s_axis_tdata[31:SAMPLE_WIDTH]};
        end
    endgenerate

    // ---- Stage 1: register accepted beat, tlast and the gain it will use ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (adv_p2) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            sample_l_p1 <= s_axis_tdata[32 +: SAMPLE_WIDTH];
            sample_r_p1 <= s_axis_tdata[0 +: SAMPLE_WIDTH];
            last_p1     <= s_axis_tlast;
            gain_p1     <= eff_gain;
        end
    end

    // ---- Stage 2: multiply, shift, saturate into the output register ----
    assign res_l = sat_lane(scale_lane(sample_l_p1, gain_p1));
    assign res_r = sat_lane(scale_lane(sample_r_p1, gain_p1));

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p2 <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_p2  <= 64'h0;
            last_p2  <= 1'b0;
            sat_l_p2 <= 1'b0;
            sat_r_p2 <= 1'b0;
        end else if (adv_p2 && vld_p1) begin
            data_p2  <= {res_l[31:0], res_r[31:0]};
            last_p2  <= last_p1;
            sat_l_p2 <= res_l[32];
            sat_r_p2 <= res_r[32];
        end
    end

    assign m_axis_tvalid = vld_p2;
    assign m_axis_tdata  = data_p2;
    assign m_axis_tlast  = last_p2;

    // ---- Output side: saturation accounting when a beat leaves stage 2 ----
    assign sat_sum = {1'b0, sat_count} + 17'(sat_l_p2) + 17'(sat_r_p2);

    always_ff @(posedge clock) begin
        if (reset || sat_clear) begin
            sat_count <= 16'h0000;
        end else if (out_fire) begin
            sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end

endmodule

// File: doc/audio_gain_stage.md
AUDIO_GAIN_STAGE -- requirements
Module: audio_gain_stage

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 24: signed sample width held in bits [SAMPLE_WIDTH-1:0] of each 32-bit lane.
REQ-002 SHALL have parameter RAMP_STEP, default 16'h0100: gain change per accepted beat during a soft-mute ramp.
REQ-003 SHALL have port clock, input, 1: single clock (AXI stream clock domain).
REQ-004 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-005 SHALL have port s_axis_tvalid, input, 1: upstream beat valid.
REQ-006 SHALL have port s_axis_tready, output, 1: this stage accepts a beat.
REQ-007 SHALL have port s_axis_tdata, input, 64: left sample in [63:32], right sample in [31:0].
REQ-008 SHALL have port s_axis_tlast, input, 1: end of DMA packet.
REQ-009 SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tdata (output, 64) and m_axis_tlast (output, 1), feeding the DMA-to-CODEC FIFO.
REQ-010 SHALL have port gain_in, input, 16: unsigned Q1.15 gain; 16'h8000 = unity.
REQ-011 SHALL have port gain_load, input, 1: one-cycle pulse that latches gain_in into the target gain.
REQ-012 SHALL have port mute, input, 1: level signal; 1 forces output toward silence.
REQ-013 SHALL have port sat_clear, input, 1: clears sat_count.
REQ-014 SHALL have port sat_count, output, 16: number of saturated lanes.
REQ-015 SHALL have port ramp_active, output, 1: effective gain differs from its destination.

Function
REQ-016 SHALL be a 2-stage pipeline:
- Stage 1: registers the beat, tlast and the effective gain.
- Stage 2: multiply, shift, saturate.
REQ-017 SHALL accept a beat when s_axis_tvalid && s_axis_tready.
REQ-018 SHALL drive s_axis_tready = !v1 || !v2 || m_axis_tready (v1 and v2 are the stage-valid flags); it SHALL contain no combinational path from s_axis_tvalid to s_axis_tready.
REQ-019 SHALL give 2-cycle latency from acceptance to m_axis_tvalid when there is no backpressure, and SHALL sustain 1 beat per cycle.
REQ-020 SHALL hold m_axis_tdata and m_axis_tlast stable while m_axis_tvalid && !m_axis_tready; no beat SHALL be dropped or duplicated.
REQ-021 SHALL compute each lane identically: out = sat(((signed sample[SAMPLE_WIDTH-1:0]) * {1'b0, gain}) >>> 15).
- Saturation range is [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
- Result is sign-extended to 32 bits.
- Bits [31:SAMPLE_WIDTH] of the input are ignored.
REQ-022 SHALL use an arithmetic shift that truncates toward negative infinity, with no rounding.
REQ-023 SHALL pass s_axis_tlast through with the same latency as its data.
REQ-024 SHALL capture the target gain on the cycle after gain_load, and the first beat accepted after that cycle SHALL use it.
REQ-025 SHALL sample the effective gain once per beat at acceptance; left and right lanes SHALL use the same gain.
REQ-026 SHALL increment sat_count by 1 per saturated lane (maximum 2 per beat) when the beat leaves stage 2.
- sat_count SHALL stick at 16'hFFFF.
- sat_clear SHALL win over a simultaneous increment.
REQ-027 SHALL apply gain_load while muted to the target only; the new target becomes audible after unmute.

Reset
REQ-028 SHALL, on reset, set:
- stage-valid flags, m_axis_tvalid, m_axis_tlast and ramp_active to 0;
- m_axis_tdata to 0;
- sat_count to 0;
- target and effective gain to 16'h8000.
REQ-029 SHALL discard in-flight beats on reset asserted mid-stream.
REQ-030 SHALL drive s_axis_tready to 0 during reset and to 1 on the first cycle after reset deasserts.

Configuration
REQ-031 SHALL, when AUDIO_GAIN_SOFT_MUTE_EN is defined:
- move the effective gain by RAMP_STEP per accepted beat toward 0 (mute=1) or toward the target (mute=0), clamping at the destination and never overshooting;
- drive ramp_active = 1 while effective gain != destination;
- let a direction change mid-ramp start from the current effective gain.
REQ-032 SHALL, when AUDIO_GAIN_SOFT_MUTE_EN is undefined:
- set the effective gain to 0 when mute=1, else to the target, from the next accepted beat;
- tie ramp_active to 0.

Verification
REQ-033 Gain 16'h8000, input {32'h0000_1FFF, 32'hFFFF_E001}, m_axis_tready=1 -> identical data appears 2 cycles after acceptance; sat_count stays 0.
REQ-034 Gain 16'hFFFF, lanes 24'h7FFFFF and 24'h800000 -> outputs 32'h007F_FFFF and 32'hFF80_0000; sat_count = 2.
REQ-035 Continuous valid with m_axis_tready toggling 1,0,0,1 -> all beats arrive in order with tlast aligned; s_axis_tready drops only while both stages are full.
REQ-036 With the macro defined, unity gain and mute asserted -> effective gain steps 8000, 7F00 ... 0000 over 128 accepted beats; ramp_active falls on the beat after reaching 0. Without the macro -> the next beat outputs 0.
REQ-037 Reset asserted with 2 beats in flight -> m_axis_tvalid=0 the next cycle; sat_count=0; the first post-reset beat uses gain 16'h8000.
